iob_counter_bounded: RTL and testbench



---
 rtl/iob_counter_bounded_pkg.sv | 11 +
 rtl/iob_counter_bounded_next.sv | 58 +++++
 rtl/iob_counter_bounded.sv | 105 ++++++++++
 tb/tb_iob_counter_bounded.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_counter_bounded_pkg.sv
// Shared encodings for the bounded counter.
//   CNT_DIR_*  : count direction select (dir_i)
//   CNT_MODE_* : behaviour at a bound (mode_i)
package iob_counter_bounded_pkg;

  localparam logic CNT_DIR_UP    = 1'b0;
  localparam logic CNT_DIR_DN    = 1'b1;
  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

endpackage

// File: rtl/iob_counter_bounded_next.sv
// Combinational next-value and bound-event function of the bounded counter.
// Ports:
//   data_i  current count
//   step_i  increment/decrement amount
//   min_i   lower bound (unsigned)
//   max_i   upper bound (unsigned)
//   dir_i   CNT_DIR_UP / CNT_DIR_DN
//   mode_i  CNT_MODE_WRAP / CNT_MODE_SAT
//   next_o  value the counter takes when enabled
//   evt_o   bound event for this step
module iob_counter_bounded_next
  import iob_counter_bounded_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [DATA_W-1:0] min_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic              dir_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] next_o,
  output logic              evt_o
);

  // One extra bit so a carry out of the top or a borrow below zero is
  // seen as out of range rather than silently wrapping modulo 2^DATA_W.
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            up_ok;
  logic            dn_ok;

  assign sum   = {1'b0, data_i} + {1'b0, step_i};
  assign diff  = {1'b0, data_i} - {1'b0, step_i};
  assign up_ok = (sum <= {1'b0, max_i});
  assign dn_ok = !diff[DATA_W] && (diff[DATA_W-1:0] >= min_i);

  always_comb begin
    next_o = data_i;
    evt_o  = 1'b0;
    if (dir_i == CNT_DIR_UP) begin
      if (up_ok) begin
        next_o = sum[DATA_W-1:0];
      end else begin
        evt_o  = 1'b1;
        next_o = (mode_i == CNT_MODE_SAT) ? max_i : min_i;
      end
    end else begin
      if (dn_ok) begin
        next_o = diff[DATA_W-1:0];
      end else begin
        evt_o  = 1'b1;
        next_o = (mode_i == CNT_MODE_SAT) ? min_i : max_i;
      end
    end
  end

endmodule

// File: rtl/iob_counter_bounded.sv
// Bounded up/down counter with programmable step, runtime bounds,
// wrap/saturate behaviour, terminal-count pulse and sticky event flag.
// Ports:
//   clk_i      clock
//   arst_n_i   asynchronous reset, active low
//   cke_i      clock enable; 0 holds all state
//   rst_i      synchronous clear (data to RST_VAL, flags to 0)
//   en_i       count enable
//   dir_i      0 up, 1 down
//   mode_i     0 wrap, 1 saturate
//   step_i     step amount
//   min_i      lower bound
//   max_i      upper bound
//   ld_i       load request
//   ld_val_i   load value
//   evt_clr_i  clears evt_o
//   data_o     registered count
//   tc_o       bound event on the last update
//   evt_o      sticky bound event
module iob_counter_bounded
  import iob_counter_bounded_pkg::*;
#(
  parameter int unsigned         DATA_W  = 32,
  parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [DATA_W-1:0] min_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  input  logic              evt_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              tc_o,
  output logic              evt_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              tc_q, tc_d;
  logic              evt_q, evt_d;
  logic [DATA_W-1:0] nxt_val;
  logic              nxt_evt;

  iob_counter_bounded_next #(
    .DATA_W (DATA_W)
  ) u_next (
    .data_i (data_q),
    .step_i (step_i),
    .min_i  (min_i),
    .max_i  (max_i),
    .dir_i  (dir_i),
    .mode_i (mode_i),
    .next_o (nxt_val),
    .evt_o  (nxt_evt)
  );

  // Priority: rst_i > ld_i > en_i > hold. A bound event in the same cycle
  // as evt_clr_i leaves evt set.
  always_comb begin
    data_d = data_q;
    tc_d   = tc_q;
    evt_d  = evt_q;
    if (cke_i) begin
      if (rst_i) begin
        data_d = RST_VAL;
        tc_d   = 1'b0;
        evt_d  = 1'b0;
      end else if (ld_i) begin
        data_d = ld_val_i;
        tc_d   = 1'b0;
        evt_d  = evt_q & ~evt_clr_i;
      end else if (en_i) begin
        data_d = nxt_val;
        tc_d   = nxt_evt;
        evt_d  = nxt_evt | (evt_q & ~evt_clr_i);
      end else begin
        tc_d   = 1'b0;
        evt_d  = evt_q & ~evt_clr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q <= RST_VAL;
      tc_q   <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
      evt_q  <= evt_d;
    end
  end

  assign data_o = data_q;
  assign tc_o   = tc_q;
  assign evt_o  = evt_q;

endmodule

// File: tb/tb_iob_counter_bounded.sv
// Directed and randomized bench for iob_counter_bounded (DATA_W = 8).
module tb_iob_counter_bounded;
  import iob_counter_bounded_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       cke, rst, en, dir, mode, ld, evt_clr;
  logic [7:0] step, min_v, max_v, ld_val;
  logic [7:0] data_o;
  logic       tc_o, evt_o;

  int total = 0;
  int bad   = 0;

  // reference state
  int m_data;
  bit m_tc;
  bit m_evt;

  iob_counter_bounded #(
    .DATA_W  (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .cke_i     (cke),
    .rst_i     (rst),
    .en_i      (en),
    .dir_i     (dir),
    .mode_i    (mode),
    .step_i    (step),
    .min_i     (min_v),
    .max_i     (max_v),
    .ld_i      (ld),
    .ld_val_i  (ld_val),
    .evt_clr_i (evt_clr),
    .data_o    (data_o),
    .tc_o      (tc_o),
    .evt_o     (evt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict from the spec rules using plain integers,
  // then compare all three outputs just after the edge.
  task automatic tick(input string tag);
    int  nd;
    bit  ntc, nevt, ev;
    int  s;
    nd   = m_data;
    ntc  = m_tc;
    nevt = m_evt;
    if (cke) begin
      if (rst) begin
        nd = 0; ntc = 0; nevt = 0;
      end else if (ld) begin
        nd = int'(ld_val); ntc = 0; nevt = m_evt && !evt_clr;
      end else if (en) begin
        ev = 0;
        if (dir == CNT_DIR_UP) begin
          s = m_data + int'(step);
          if (s <= int'(max_v)) nd = s;
          else begin ev = 1; nd = (mode == CNT_MODE_SAT) ? int'(max_v) : int'(min_v); end
        end else begin
          s = m_data - int'(step);
          if (s >= 0 && s >= int'(min_v)) nd = s;
          else begin ev = 1; nd = (mode == CNT_MODE_SAT) ? int'(min_v) : int'(max_v); end
        end
        ntc  = ev;
        nevt = ev || (m_evt && !evt_clr);
      end else begin
        ntc = 0; nevt = m_evt && !evt_clr;
      end
    end
    @(posedge clk);
    m_data = nd; m_tc = ntc; m_evt = nevt;
    #1;
    check({tag, ".data"}, 32'(data_o), 32'(m_data));
    check({tag, ".tc"},   32'(tc_o),   32'(m_tc));
    check({tag, ".evt"},  32'(evt_o),  32'(m_evt));
  endtask

  task automatic idle();
    cke = 1; rst = 0; en = 0; ld = 0; evt_clr = 0;
  endtask

  logic [7:0] exp_up [4];
  logic [7:0] exp_dn [3];
  logic       exp_dn_tc [3];

  initial begin
    exp_up    = '{8'd8, 8'd2, 8'd5, 8'd8};
    exp_dn    = '{8'd7, 8'd4, 8'd4};
    exp_dn_tc = '{1'b0, 1'b1, 1'b1};

    arst_n = 0;
    idle();
    dir = CNT_DIR_UP; mode = CNT_MODE_WRAP;
    step = 0; min_v = 0; max_v = 8'hFF; ld_val = 0;
    m_data = 0; m_tc = 0; m_evt = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.data", 32'(data_o), 0);
    check("reset.tc",   32'(tc_o),   0);
    check("reset.evt",  32'(evt_o),  0);
    @(negedge clk) arst_n = 1;

    // reach 0x37 with flags set, then async reset mid-cycle
    ld = 1; ld_val = 8'h37; tick("ld37"); ld = 0;
    en = 1; step = 1; max_v = 8'h37; mode = CNT_MODE_SAT; tick("sat37");
    check("sat37.tc_const", 32'(tc_o), 1);
    en = 0;
    #2 arst_n = 0;
    #1;
    check("arst.data", 32'(data_o), 0);
    check("arst.tc",   32'(tc_o),   0);
    check("arst.evt",  32'(evt_o),  0);
    m_data = 0; m_tc = 0; m_evt = 0;
    @(negedge clk) arst_n = 1;
    tick("post_arst");

    ld = 1; ld_val = 8'h10; tick("ld10"); ld = 0;
    check("ld10.const", 32'(data_o), 32'h10);
    rst = 1; tick("rst"); rst = 0;
    check("rst.const", 32'(data_o), 0);
    ld = 1; ld_val = 8'h55; rst = 1; tick("rst_ld"); idle();
    check("rst_ld.const", 32'(data_o), 0);

    // up wrap
    min_v = 2; max_v = 9; step = 3; mode = CNT_MODE_WRAP; dir = CNT_DIR_UP;
    ld = 1; ld_val = 5; tick("upw_ld"); ld = 0;
    en = 1;
    for (int i = 0; i < 4; i++) begin
      tick("upw");
      check("upw.seq", 32'(data_o), 32'(exp_up[i]));
      check("upw.tc_seq", 32'(tc_o), (i == 1) ? 1 : 0);
    end
    check("upw.evt_const", 32'(evt_o), 1);
    en = 0;

    // down saturate
    min_v = 4; max_v = 200; step = 5; dir = CNT_DIR_DN; mode = CNT_MODE_SAT;
    ld = 1; ld_val = 12; tick("dns_ld"); ld = 0;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick("dns");
      check("dns.seq", 32'(data_o), 32'(exp_dn[i]));
      check("dns.tc_seq", 32'(tc_o), 32'(exp_dn_tc[i]));
    end
    en = 0;

    // full range carry / borrow
    min_v = 0; max_v = 8'hFF; step = 1; mode = CNT_MODE_WRAP; dir = CNT_DIR_UP;
    ld = 1; ld_val = 8'hFF; tick("fr_ldff"); ld = 0;
    en = 1; tick("fr_upwrap"); en = 0;
    check("fr_upwrap.const", 32'({tc_o, data_o}), 32'h100);
    dir = CNT_DIR_DN; en = 1; tick("fr_dnwrap"); en = 0;
    check("fr_dnwrap.const", 32'(data_o), 32'hFF);
    dir = CNT_DIR_UP; step = 8'h80;
    ld = 1; ld_val = 8'h90; tick("fr_ld90"); ld = 0;
    en = 1; tick("fr_big"); en = 0;
    check("fr_big.const", 32'({tc_o, data_o}), 32'h100);
    mode = CNT_MODE_SAT;
    ld = 1; ld_val = 8'h90; tick("fr_ld90s"); ld = 0;
    en = 1; tick("fr_bigsat"); en = 0;
    check("fr_bigsat.const", 32'(data_o), 32'hFF);

    // clock-enable gating: tc holds high, data holds
    mode = CNT_MODE_WRAP; step = 1;
    ld = 1; ld_val = 8'hFF; tick("cke_ld"); ld = 0;
    en = 1; tick("cke_evt");
    cke = 0;
    for (int i = 0; i < 5; i++) begin
      tick("cke_off");
      check("cke_off.const", 32'({tc_o, data_o}), 32'h100);
    end
    idle();

    // evt clear interaction
    rst = 1; tick("evt_rst"); rst = 0;
    min_v = 2; max_v = 9; step = 3;
    ld = 1; ld_val = 9; tick("evt_ld"); ld = 0;
    en = 1; evt_clr = 1; tick("evt_setclr");
    check("evt_setclr.const", 32'(evt_o), 1);
    en = 0; tick("evt_hold");
    tick("evt_clr");
    check("evt_clr.const", 32'(evt_o), 0);
    evt_clr = 0;

    // step 0 with count outside bounds
    step = 0; max_v = 8'h40; min_v = 8'h10;
    ld = 1; ld_val = 8'h50; tick("s0_ld"); ld = 0;
    en = 1; tick("s0_out"); en = 0;
    check("s0_out.const", 32'({tc_o, data_o}), 32'h110);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cke     = ($urandom_range(0, 9) != 0);
      rst     = ($urandom_range(0, 39) == 0);
      ld      = ($urandom_range(0, 11) == 0);
      en      = ($urandom_range(0, 3) != 0);
      evt_clr = ($urandom_range(0, 9) == 0);
      dir     = 1'($urandom);
      mode    = 1'($urandom);
      step    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      min_v   = 8'($urandom_range(0, 80));
      max_v   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(120, 255));
      ld_val  = 8'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
